// File: rtl/cypher_stream_pkg.sv
// cypher_stream_pkg: shared types and defaults for the cypher stream bridge.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
// Holds the session FSM state enum, the 9-bit byte count type, the FIFO_DEPTH and
// FILL_BYTE defaults, and the length-byte decoder (a length byte of 0 means 256).
package cypher_stream_pkg;

    localparam int         FIFO_DEPTH_DEF = 16;
    localparam logic [7:0] FILL_BYTE_DEF  = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LEN    = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    // Nine bits so that a full 256-byte session can be counted.
    typedef logic [8:0] cnt_t;

    function automatic cnt_t len_decode(input logic [7:0] len_byte);
        return (len_byte == 8'h00) ? 9'd256 : {1'b0, len_byte};
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: show-ahead byte FIFO with synchronous flush.
// Latency: a pushed byte is visible on head_dat the cycle after the push.
// Backpressure: a push while full succeeds only together with a pop; a pop while empty is ignored.
// Ports: i_Clk, i_Rst_L (sync, active-low), flush, push/push_dat, pop, head_dat, full, empty.
// DEPTH must be a power of two so the pointers wrap naturally.
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       flush,
    input  logic       push,
    input  logic [7:0] push_dat,
    input  logic       pop,
    output logic [7:0] head_dat,
    output logic       full,
    output logic       empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    // A pop on an empty FIFO is dropped, so a simultaneous push/pop there is a push only.
    assign do_pop   = pop && !empty;
    // A pop frees the slot this push needs, so push+pop on a full FIFO both succeed.
    assign do_push  = push && (!full || do_pop);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge i_Clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/cypher_stream_bridge.sv
// cypher_stream_bridge: SPI byte stream <-> cipher core bridge for one length-prefixed session.
// Latency: RX byte on io_plaintext 1 cycle after i_RX_DV; o_TX_DV 1 cycle after i_TX_Req.
// Backpressure: plaintext FIFO drops RX bytes when full; io_cypher_ready low when cyphertext FIFO full.
// Ports: i_Clk, i_Rst_L (sync, active-low), i_Start, i_RX_DV/i_RX_Byte, i_TX_Req,
//        o_TX_DV/o_TX_Byte, io_plaintext/io_plain_valid/io_plain_ready,
//        io_cyphertext/io_cypher_valid/io_cypher_ready, o_Busy, o_Done.
// Optional macro CYPHER_STREAM_BRIDGE_ERR_EN adds sticky o_Overflow / o_Underflow flags.
module cypher_stream_bridge
    import cypher_stream_pkg::*;
#(
    parameter int         FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter logic [7:0] FILL_BYTE  = FILL_BYTE_DEF
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Start,
    input  logic       i_RX_DV,
    input  logic [7:0] i_RX_Byte,
    input  logic       i_TX_Req,
    output logic       o_TX_DV,
    output logic [7:0] o_TX_Byte,
    output logic [7:0] io_plaintext,
    output logic       io_plain_valid,
    input  logic       io_plain_ready,
    input  logic [7:0] io_cyphertext,
    input  logic       io_cypher_valid,
    output logic       io_cypher_ready,
    output logic       o_Busy,
    output logic       o_Done
`ifdef CYPHER_STREAM_BRIDGE_ERR_EN
    ,
    output logic       o_Overflow,
    output logic       o_Underflow
`endif
);

    state_t state;
    state_t state_nxt;
    cnt_t   len_q;
    cnt_t   rx_cnt;
    cnt_t   tx_cnt;

    logic       p_push, p_pop, p_full, p_empty;
    logic [7:0] p_head;
    logic       c_push, c_pop, c_full, c_empty;
    logic [7:0] c_head;

    logic in_stream;
    logic in_xfer;
    logic rx_take;
    logic tx_serve;

    assign in_stream = (state == ST_STREAM);
    assign in_xfer   = (state == ST_STREAM) || (state == ST_DRAIN);

    // RX bytes only matter in STREAM and only until N have been accepted.
    assign rx_take  = i_RX_DV && in_stream && (rx_cnt != len_q) && !i_Start;
    assign p_pop    = !p_empty && io_plain_ready;
    assign p_push   = rx_take && (!p_full || p_pop);

    assign c_push   = io_cypher_valid && io_cypher_ready;
    assign tx_serve = i_TX_Req && in_xfer && !c_empty;
    assign c_pop    = tx_serve;

    assign io_plain_valid = !p_empty;
    assign io_plaintext   = p_head;

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_plain_fifo (
        .i_Clk    (i_Clk),
        .i_Rst_L  (i_Rst_L),
        .flush    (i_Start),
        .push     (p_push),
        .push_dat (i_RX_Byte),
        .pop      (p_pop),
        .head_dat (p_head),
        .full     (p_full),
        .empty    (p_empty)
    );

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_cypher_fifo (
        .i_Clk    (i_Clk),
        .i_Rst_L  (i_Rst_L),
        .flush    (i_Start),
        .push     (c_push),
        .push_dat (io_cyphertext),
        .pop      (c_pop),
        .head_dat (c_head),
        .full     (c_full),
        .empty    (c_empty)
    );

    // FSM: state register.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // FSM: next state. i_Start from any state opens (or restarts) a session.
    always_comb begin
        state_nxt = state;
        if (i_Start) begin
            state_nxt = ST_LEN;
        end else begin
            case (state)
                ST_IDLE:   state_nxt = ST_IDLE;
                ST_LEN:    if (i_RX_DV) state_nxt = ST_STREAM;
                ST_STREAM: if (rx_cnt == len_q) state_nxt = ST_DRAIN;
                ST_DRAIN:  if (tx_cnt == len_q) state_nxt = ST_IDLE;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    // FSM: outputs. Done is suppressed when the same cycle aborts or resets the session.
    always_comb begin
        o_Busy          = (state != ST_IDLE);
        o_Done          = (state == ST_DRAIN) && (tx_cnt == len_q) && !i_Start && i_Rst_L;
        io_cypher_ready = in_xfer && !c_full;
    end

    // Session counters and the TX byte register.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            len_q     <= '0;
            rx_cnt    <= '0;
            tx_cnt    <= '0;
            o_TX_DV   <= 1'b0;
            o_TX_Byte <= 8'h00;
        end else begin
            o_TX_DV <= i_TX_Req;
            if (i_TX_Req) o_TX_Byte <= tx_serve ? c_head : FILL_BYTE;

            if (i_Start) begin
                len_q  <= '0;
                rx_cnt <= '0;
                tx_cnt <= '0;
            end else begin
                if ((state == ST_LEN) && i_RX_DV) len_q <= len_decode(i_RX_Byte);
                if (p_push) rx_cnt <= rx_cnt + 9'd1;
                // Fill bytes are never counted; real bytes stop counting at N.
                if (tx_serve && (tx_cnt != len_q)) tx_cnt <= tx_cnt + 9'd1;
            end
        end
    end

`ifdef CYPHER_STREAM_BRIDGE_ERR_EN
    logic rx_drop;
    logic tx_starve;

    assign rx_drop   = rx_take && p_full && !p_pop;
    // Fill bytes sent outside a session are expected and do not flag.
    assign tx_starve = i_TX_Req && in_xfer && c_empty;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L || i_Start) begin
            o_Overflow  <= 1'b0;
            o_Underflow <= 1'b0;
        end else begin
            if (rx_drop)   o_Overflow  <= 1'b1;
            if (tx_starve) o_Underflow <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/cypher_stream_bridge.md
CYPHER_STREAM_BRIDGE -- requirements
Module: cypher_stream_bridge

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, plaintext and cyphertext FIFO depth in bytes; power of two, 4..256.
REQ-002 SHALL have parameter FILL_BYTE, default 8'h00, byte returned to SPI when no cyphertext is available.
REQ-003 i_Clk  in  1  single clock; all logic on rising edge.
REQ-004 i_Rst_L  in  1  reset; synchronous, active-low.
REQ-005 i_Start  in  1  one-cycle pulse from the key/nonce manager that opens a session.
REQ-006 i_RX_DV  in  1  one-cycle pulse from the SPI slave; i_RX_Byte is valid.
REQ-007 i_RX_Byte  in  8  byte received on MOSI.
REQ-008 i_TX_Req  in  1  one-cycle pulse from the SPI slave requesting the next MISO byte.
REQ-009 o_TX_DV  out  1  one-cycle pulse; o_TX_Byte is valid.
REQ-010 o_TX_Byte  out  8  byte to serialize on MISO.
REQ-011 io_plaintext  out  8 / io_plain_valid  out  1 / io_plain_ready  in  1  plaintext stream to the cipher core.
REQ-012 io_cyphertext  in  8 / io_cypher_valid  in  1 / io_cypher_ready  out  1  cyphertext stream from the cipher core.
REQ-013 o_Busy  out  1  high in any state except IDLE.
REQ-014 o_Done  out  1  one-cycle pulse when the session completes.

Function
REQ-015 FSM states: IDLE, LEN, STREAM, DRAIN.
- IDLE -> LEN on i_Start.
- LEN -> STREAM on i_RX_DV, latching the length N = i_RX_Byte (0 means 256).
- STREAM -> DRAIN when N plaintext bytes have been accepted.
- DRAIN -> IDLE when N bytes have been delivered on TX; o_Done pulses in that cycle.
REQ-016 In IDLE and DRAIN, RX bytes SHALL be ignored, and i_Start in IDLE SHALL also clear both FIFOs and all counters.
REQ-017 i_Start in LEN, STREAM or DRAIN SHALL abort the session: flush both FIFOs, clear counters, go to LEN.
REQ-018 STREAM: each i_RX_DV pushes i_RX_Byte into the plaintext FIFO and increments the 9-bit rx count.
- A byte arriving with the FIFO full is dropped, is not counted, and sets the overflow flag.
REQ-019 Plaintext FIFO SHALL be show-ahead: io_plain_valid = not empty; io_plaintext = head; pop when valid and ready.
- A pushed byte is visible on io_plaintext the cycle after i_RX_DV.
REQ-020 io_cypher_ready SHALL be high only in STREAM or DRAIN with the cyphertext FIFO not full; push when valid and ready.
REQ-021 On i_TX_Req, the next cycle SHALL assert o_TX_DV with the cyphertext FIFO head, pop it, and increment the 9-bit tx count.
- If the FIFO is empty, or the state is IDLE/LEN, send FILL_BYTE, do not count it, and set the underflow flag (the underflow flag only in STREAM/DRAIN).
REQ-022 Simultaneous push and pop on a full FIFO SHALL both succeed; simultaneous push and pop on an empty FIFO SHALL see the push only.
REQ-023 Both counters SHALL stop at N; no wrap.
REQ-024 o_TX_DV and o_Done SHALL never be asserted for more than one consecutive cycle per request or session.

Reset
REQ-025 While i_Rst_L = 0 at a clock edge, the block SHALL enter this state:
- FSM in IDLE; FIFOs empty; counters and N at 0; flags cleared.
- o_TX_DV=0, o_TX_Byte=8'h00, io_plain_valid=0, io_cypher_ready=0, o_Busy=0, o_Done=0.
REQ-026 Reset mid-session SHALL discard all buffered data with no o_Done.

Configuration
REQ-027 Macro CYPHER_STREAM_BRIDGE_ERR_EN: when defined, outputs o_Overflow and o_Underflow (1 bit each) SHALL exist.
- Both are sticky and cleared by i_Start or reset.
- When undefined, these ports and flag registers SHALL NOT exist, and dropped/underflow behaviour is otherwise identical.

Structure
REQ-028 Package cypher_stream_pkg SHALL hold the FSM state enum, the 9-bit count type, and the FIFO_DEPTH and FILL_BYTE defaults.
REQ-029 Sub-module byte_fifo (show-ahead, parameter DEPTH, push/pop/full/empty/flush) SHALL be instantiated twice.

Verification
REQ-030 Length: reset, i_Start, RX 8'h03, then 11 22 33; core ready=1 echoes each byte XOR 8'hFF; three i_TX_Req -> o_TX_Byte EE DD CC, then o_Done one pulse, o_Busy=0.
REQ-031 Overflow: FIFO_DEPTH=4, N=8, io_plain_ready=0, 6 RX bytes -> first 4 buffered, 2 dropped, o_Overflow=1, FSM remains STREAM.
REQ-032 Underflow: i_TX_Req in STREAM with empty cyphertext FIFO -> o_TX_Byte=8'h00, tx count unchanged, o_Underflow=1.
REQ-033 Length 0: RX 8'h00 -> 256 bytes accepted, then DRAIN; 256 TX bytes -> o_Done.
REQ-034 Abort and reset: i_Start mid-STREAM with 2 buffered -> FIFOs empty, state LEN; i_Rst_L=0 mid-DRAIN -> all REQ-025 values next cycle.
REQ-035 Full boundary: push and pop in the same cycle on a full FIFO -> occupancy stays at DEPTH with no overflow.
